// File: rtl/rx_front_pkg.sv
// Shared constants and elaboration-time helpers for the RFID receive front end.
// Also used by the demod block so that both sides agree on strobe period and align phase.
package rx_front_pkg;

    localparam int unsigned DefaultN         = 10;
    localparam int unsigned DefaultAlignLoad = DefaultN / 2;
    localparam int unsigned MaxVoteW         = 7;

    // Ceiling log2, never less than 1 so that a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned b = 1; b < 32; b++) begin
            if ((32'd1 << b) < value) begin
                w = b + 1;
            end
        end
        return w;
    endfunction

    function automatic bit vote_w_legal(input int unsigned w);
        return (w >= 1) && (w <= MaxVoteW) && ((w % 2) == 1);
    endfunction

    // Illegal window sizes fall back to the nearest legal odd width not above the request.
    function automatic int unsigned vote_w_fix(input int unsigned w);
        int unsigned r;
        if (vote_w_legal(w)) begin
            r = w;
        end else if (w == 0) begin
            r = 1;
        end else if (w > MaxVoteW) begin
            r = MaxVoteW;
        end else begin
            r = w - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/strb_gen_ld.sv
// Loadable strobe generator: free-running modulo-N counter with enable and phase reload.
// fire is the combinational "strobe this edge" term; strb is its registered copy.
module strb_gen_ld
    import rx_front_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned CNT_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             fire,
    output logic             strb
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             strb_q;

    // A load in the terminal cycle wins, so the coincident strobe is dropped.
    assign fire = en && !load && (cnt_q == CntLast);
    assign strb = strb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            strb_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            strb_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= load_val;
            strb_q <= 1'b0;
        end else if (cnt_q == CntLast) begin
            cnt_q  <= '0;
            strb_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            strb_q <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_sampler.sv
// Multi-channel receive sampler: per-channel synchroniser, majority glitch filter and
// edge detector, plus a shared loadable strobe that captures all filtered levels at once.
module multi_sampler
    import rx_front_pkg::*;
#(
    parameter int unsigned CH          = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned VOTE_W      = 3,
    parameter int unsigned N           = DefaultN,
    parameter int unsigned ALIGN_LOAD  = N / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          align,
    input  logic [CH-1:0] rx_in,
    output logic [CH-1:0] filt_dat,
    output logic [CH-1:0] out_edge,
    output logic [CH-1:0] out_dat,
    output logic          out_vld
);

    localparam int unsigned VoteW = vote_w_fix(VOTE_W);
    localparam int unsigned CntW  = clog2(N);

    logic          fire;
    logic [CH-1:0] out_dat_q;

    strb_gen_ld #(
        .N     (N),
        .CNT_W (CntW)
    ) u_strb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (align),
        .load_val (CntW'(ALIGN_LOAD)),
        .fire     (fire),
        .strb     (out_vld)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [VoteW-1:0]       win_q;
        logic [3:0]             ones;
        logic                   maj;
        logic                   filt_q;
        logic                   prev_q;
        logic                   edge_q;

        always_comb begin
            ones = '0;
            for (int unsigned k = 0; k < VoteW; k++) begin
                ones = ones + 4'(win_q[k]);
            end
            maj = (ones > 4'(VoteW / 2));
        end

        // Pure flop chain into the vote window; nothing combinational between stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                win_q  <= '0;
                filt_q <= 1'b0;
                prev_q <= 1'b0;
                edge_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in[i]};
                win_q  <= (win_q << 1) | VoteW'(sync_q[SYNC_STAGES-1]);
                filt_q <= maj;
                prev_q <= filt_q;
                edge_q <= filt_q ^ prev_q;
            end
        end

        assign filt_dat[i] = filt_q;
        assign out_edge[i] = edge_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat_q <= '0;
        end else if (fire) begin
            out_dat_q <= filt_dat;
        end
    end

    assign out_dat = out_dat_q;

endmodule
